// File: rtl/dh_pkg.sv
// Shared definitions for the Dh_cal request scheduler.
//   DH_TAPS    : complex taps summed per Dh job
//   dh_state_t : scheduler FSM state encoding
//   id_w()     : width of a requester id for a given requester count
package dh_pkg;

    localparam int DH_TAPS = 8;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FETCH    = 3'd1,
        ST_DRAIN    = 3'd2,
        ST_WAIT_RES = 3'd3,
        ST_DONE     = 3'd4
    } dh_state_t;

    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set bit of req searching upward
// from (ptr+1) mod NUM_REQ.
//   req      : request vector
//   ptr      : id of the last winner
//   grant    : one-hot winner (all zero when no request)
//   grant_id : binary id of the winner
//   found    : at least one request is set
module rr_arbiter
    import dh_pkg::*;
#(
    parameter int NUM_REQ = 4,
    localparam int ID_W = id_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_id,
    output logic               found
);

    logic [ID_W-1:0] idx;

    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        idx      = '0;
        // i runs 1..NUM_REQ so the previous winner is checked last
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = ID_W'((int'(ptr) + i) % NUM_REQ);
            if (!found && req[idx]) begin
                found     = 1'b1;
                grant_id  = idx;
                grant[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dh_sched.sv
// Round-robin scheduler sharing one Dh_cal accumulator between NUM_REQ
// requesters. Grants one requester, streams its 8 coefficients from the
// channel RAM into Dh_cal, and returns the tagged result (or a timeout error).
//   clk, rst           : clock, asynchronous active-low reset
//   req, req_base      : level requests and per-requester base addresses
//   ack                : one-hot single-cycle grant
//   mem_rd_en/mem_addr : RAM read port, data returns next cycle on mem_rdata_*
//   dh_en, dh_in_*     : sample stream into Dh_cal
//   dh_out, dh_result_valid : Dh_cal result
//   res_valid/id/data/err   : tagged result strobe
//   busy               : scheduler not idle
module dh_sched
    import dh_pkg::*;
#(
    parameter int Q       = 8,
    parameter int N       = 16,
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 31,
    localparam int ID_W   = id_w(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_base,
    output logic [NUM_REQ-1:0]        ack,
    output logic                      mem_rd_en,
    output logic [ADDR_W-1:0]         mem_addr,
    input  logic [N-1:0]              mem_rdata_real,
    input  logic [N-1:0]              mem_rdata_im,
    output logic                      dh_en,
    output logic [N-1:0]              dh_in_real,
    output logic [N-1:0]              dh_in_im,
    input  logic [N-1:0]              dh_out,
    input  logic                      dh_result_valid,
    output logic                      res_valid,
    output logic [ID_W-1:0]           res_id,
    output logic [N-1:0]              res_data,
    output logic                      res_err,
    output logic                      busy
);

    localparam int CNT_W = $clog2(DH_TAPS);
    localparam int WD_W  = $clog2(TIMEOUT + 1);

    // Q is only consumed by Dh_cal; sanity-check the parameter set here
    if (NUM_REQ < 2 || NUM_REQ > 8 || Q >= N) begin : g_param_check
        $error("dh_sched: unsupported parameter set");
    end

    dh_state_t                        state;
    logic [ID_W-1:0]                  ptr;
    logic [ID_W-1:0]                  id;
    logic [CNT_W-1:0]                 cnt;
    logic [WD_W-1:0]                  wd;
    logic [N-1:0]                     hold_real, hold_im;
    logic [NUM_REQ-1:0][ADDR_W-1:0]   base_arr;
    logic [NUM_REQ-1:0]               grant;
    logic [ID_W-1:0]                  grant_id;
    logic                             found;

    assign base_arr = req_base;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req      (req),
        .ptr      (ptr),
        .grant    (grant),
        .grant_id (grant_id),
        .found    (found)
    );

    // Grant is decided in the same cycle the request is seen in IDLE;
    // gated by rst so every output reads 0 while reset is held.
    assign ack  = (state == ST_IDLE && rst) ? grant : '0;
    assign busy = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            ptr       <= ID_W'(NUM_REQ - 1);
            id        <= '0;
            cnt       <= '0;
            wd        <= '0;
            mem_rd_en <= 1'b0;
            mem_addr  <= '0;
            res_valid <= 1'b0;
            res_id    <= '0;
            res_data  <= '0;
            res_err   <= 1'b0;
        end else begin
            res_valid <= 1'b0;
            res_err   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (found) begin
                        ptr       <= grant_id;
                        id        <= grant_id;
                        mem_rd_en <= 1'b1;
                        mem_addr  <= base_arr[grant_id];
                        cnt       <= '0;
                        state     <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (cnt == CNT_W'(DH_TAPS - 1)) begin
                        mem_rd_en <= 1'b0;
                        state     <= ST_DRAIN;
                    end else begin
                        cnt      <= cnt + CNT_W'(1);
                        mem_addr <= mem_addr + ADDR_W'(1);  // wraps mod 2^ADDR_W
                    end
                end
                ST_DRAIN: begin
                    wd    <= '0;
                    state <= ST_WAIT_RES;
                end
                ST_WAIT_RES: begin
                    if (dh_result_valid) begin
                        res_valid <= 1'b1;
                        res_id    <= id;
                        res_data  <= dh_out;
                        state     <= ST_DONE;
                    end else if (wd == WD_W'(TIMEOUT)) begin
                        res_valid <= 1'b1;
                        res_id    <= id;
                        res_data  <= '0;
                        res_err   <= 1'b1;
                        state     <= ST_DONE;
                    end else begin
                        wd <= wd + WD_W'(1);
                    end
                end
                ST_DONE:  state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    // RAM data arrives one cycle after the read strobe, so the delayed strobe
    // lines up with it and the data passes straight through to Dh_cal.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dh_en     <= 1'b0;
            hold_real <= '0;
            hold_im   <= '0;
        end else begin
            dh_en     <= mem_rd_en;
            hold_real <= dh_in_real;
            hold_im   <= dh_in_im;
        end
    end

    assign dh_in_real = dh_en ? mem_rdata_real : hold_real;
    assign dh_in_im   = dh_en ? mem_rdata_im   : hold_im;

endmodule

// File: doc/dh_sched.md
Name: dh_sched

Overview:
- Round-robin scheduler that shares one Dh_cal accumulator (sum of |Hq|^2 over 8 complex taps) between NUM_REQ requesters.
- For the granted requester it fetches 8 consecutive complex coefficients from the shared channel-coefficient RAM (1-cycle read latency), streams them to Dh_cal as single-cycle Dh_en pulses, and captures the result.
- It returns the result tagged with the requester id.
- Sits between the per-user channel-estimation front ends and the detector's norm/ordering stage.

Parameters:
- Q, 8, fractional bits of coefficient format (passed through to Dh_cal).
- N, 16, coefficient and result word width.
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_W, 8, coefficient RAM address width.
- TIMEOUT, 31, max cycles in WAIT_RES before abort.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-low.
- req  in  NUM_REQ  level request per requester.
- req_base  in  NUM_REQ*ADDR_W  base address per requester, slice i = requester i.
- ack  out  NUM_REQ  one-hot, one-cycle grant pulse.
- mem_rd_en  out  1  RAM read strobe.
- mem_addr  out  ADDR_W  RAM read address.
- mem_rdata_real  in  N  RAM real data, valid the cycle after mem_rd_en.
- mem_rdata_im  in  N  RAM imag data, valid the cycle after mem_rd_en.
- dh_en  out  1  to Dh_cal Dh_en.
- dh_in_real  out  N  to Dh_cal in_real.
- dh_in_im  out  N  to Dh_cal in_im.
- dh_out  in  N  from Dh_cal Dh_out.
- dh_result_valid  in  1  from Dh_cal Dh_result_valid.
- res_valid  out  1  one-cycle result strobe.
- res_id  out  clog2(NUM_REQ)  requester id of result.
- res_data  out  N  Dh result.
- res_err  out  1  with res_valid: timeout abort, res_data = 0.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (rst low, async): state IDLE; all outputs 0; rr pointer = NUM_REQ-1, so requester 0 wins first; fetch counter 0.
- FSM states: IDLE, FETCH, DRAIN, WAIT_RES, DONE.
- IDLE: if any req bit set, select the first set bit searching from (ptr+1) mod NUM_REQ upward.
  - Same cycle (G): ack[i]=1, latch id and req_base[i], ptr<=i; next state FETCH.
  - No req: stay in IDLE.
- Requester protocol: requester drops req the cycle after ack. A req still high in IDLE is treated as a new request.
- FETCH, cycles G+1..G+8: mem_rd_en=1, mem_addr = base+k for k=0..7; address wraps modulo 2^ADDR_W. After k=7, go to DRAIN.
- Data alignment: dh_en is mem_rd_en delayed one register; dh_in_real/dh_in_im = mem_rdata registered combinationally-through in the same cycle (no extra delay). dh_en is therefore high G+2..G+9, exactly 8 pulses, back-to-back.
- DRAIN (G+9): last dh_en issued; go to WAIT_RES with watchdog cleared.
- WAIT_RES: Dh_cal asserts dh_result_valid at G+10.
  - On dh_result_valid: capture dh_out, go to DONE.
  - Watchdog counts cycles in WAIT_RES; when it reaches TIMEOUT, go to DONE with err flag set.
- DONE (G+11): res_valid=1, res_id, res_data (0 if err), res_err; then IDLE. Next grant earliest G+12.
- Nominal latency grant to res_valid: 11 cycles. Per-job throughput: 12 cycles.
- dh_en must never be high in the cycle dh_result_valid is high; Dh_cal's internal clear has priority and would drop the sample. The FSM guarantees this by not granting until DONE.
- dh_result_valid seen outside WAIT_RES: ignored (no capture, no state change).
- dh_in_real/dh_in_im hold their last value when dh_en is low.
- req changes during FETCH..DONE: ignored; arbitration happens only in IDLE.
- Fairness: a continuously asserted requester waits at most NUM_REQ-1 jobs.
- Reset mid-operation: immediate return to IDLE, no res_valid for the aborted job, ptr reset.

Decomposition:
- Shared package dh_pkg holds:
  - constant DH_TAPS=8.
  - localparams for FSM state encoding.
  - ID_W = clog2(NUM_REQ) function.
- One natural sub-module: rr_arbiter, combinational one-hot round-robin pick from req vector and ptr, reused elsewhere.
- Dh_cal itself is instantiated by the parent, not inside dh_sched.

Test Plan:
- Single request: req[0], base 0x10, RAM[0x10..0x17] = real 0x0100, im 0x0000 -> ack[0] at G; mem_addr 0x10..0x17 at G+1..G+8; 8 dh_en pulses G+2..G+9; res_valid at G+11 with res_id=0, res_data=0x0800, res_err=0.
- Mixed taps: real=0x0080, im=0x0080 (0.5+0.5j) -> each SoP 0x0080, res_data=0x0400.
- Round robin: req=4'b1111 held high -> grants in order 0,1,2,3,0; each grant 12 cycles apart; req[2] alone mid-sequence is served after the current job.
- Address wrap: base 0xFC -> mem_addr 0xFC,0xFD,0xFE,0xFF,0x00..0x03; result matches the model.
- Timeout: Dh_cal stub never asserts dh_result_valid -> res_valid with res_err=1, res_data=0 at TIMEOUT+1 cycles after entering WAIT_RES; next request is then served normally.
- Reset mid-FETCH: rst low at G+4 -> all outputs 0 asynchronously, no res_valid; after release, req[1] is granted first and completes correctly.
